// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions for the packet FIFO.
//   AXIS_DATA_W / AXIS_DEPTH : default tdata width and beat capacity
//   keep_w()                 : tkeep width for a given tdata width
//   axis_beat_t              : one stored beat {tdata, tkeep, tlast} at the default width
package axis_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_DEPTH  = 16;

  // One tkeep bit per tdata byte.
  function automatic int unsigned keep_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned AXIS_KEEP_W = keep_w(AXIS_DATA_W);

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: one write port, one registered read port.
//   clk, rst          : clock, synchronous active-high reset (clears the read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates on the next edge and holds otherwise
//   rd_data           : registered read data
module axis_fifo_ram #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value unless a new read is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream beat FIFO with optional store-and-forward packet mode.
//   aclk, areset          : clock, synchronous active-high reset
//   s_axis_*              : upstream slave port (tready = space available, registered)
//   m_axis_*              : downstream master port, registered first-word-fall-through
//   occupancy             : beats held in storage (excludes the beat in the output register)
//   pkt_count             : complete packets (tlast beats) held in storage
// In PKT_MODE a beat leaves storage only once a whole packet is stored, except for a
// packet larger than the FIFO, which is streamed cut-through until its tlast leaves.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W   = AXIS_DATA_W,
  parameter int unsigned DEPTH    = AXIS_DEPTH,
  parameter bit          PKT_MODE = 1'b1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic [DATA_W/8-1:0]        s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

  localparam int unsigned KEEP_W = keep_w(DATA_W);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned BEAT_W = DATA_W + KEEP_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } beat_t;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [CW-1:0]    pkt_q, pkt_d;
  logic             force_q, force_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;
  // Shadow of each slot's tlast so packet accounting needs no RAM read.
  logic [DEPTH-1:0] last_q, last_d;

  logic             wr_en;
  logic             rd_en;
  logic             rd_last;
  logic             eligible;
  beat_t            wr_beat;
  beat_t            rd_beat;
  logic [BEAT_W-1:0] rd_data;

  assign wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

  // Next-state for pointers, counters, release flag and output valid.
  always_comb begin
    wr_en    = s_axis_tvalid & s_ready_q;
    rd_last  = last_q[rd_ptr_q];
    // A forced release may outrun the upstream writer, so storage must be non-empty too.
    eligible = (occ_q != '0) && (!PKT_MODE || (pkt_q != '0) || force_q);
    // Refill the output register when it is empty or being consumed this cycle.
    rd_en    = eligible & (!m_valid_q | m_axis_tready);

    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(rd_en);
    occ_d     = occ_q + CW'(wr_en) - CW'(rd_en);
    pkt_d     = pkt_q + CW'(wr_en & s_axis_tlast) - CW'(rd_en & rd_last);
    m_valid_d = rd_en | (m_valid_q & ~m_axis_tready);

    last_d = last_q;
    if (wr_en) begin
      last_d[wr_ptr_q] = s_axis_tlast;
    end

    force_d = 1'b0;
    if (PKT_MODE) begin
      force_d = force_q;
      if (rd_en & rd_last) begin
        force_d = 1'b0;
      end else if ((occ_q == CW'(DEPTH)) && (pkt_q == '0)) begin
        // Full with no complete packet: nothing could ever leave otherwise.
        force_d = 1'b1;
      end
    end

    // Registered, so full-cycle reads only reopen the input on the following cycle.
    s_ready_d = (occ_d < CW'(DEPTH));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      pkt_q     <= '0;
      force_q   <= 1'b0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      last_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      pkt_q     <= pkt_d;
      force_q   <= force_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      last_q    <= last_d;
    end
  end

  // The RAM read register doubles as the downstream data register.
  axis_fifo_ram #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign rd_beat       = beat_t'(rd_data);
  assign m_axis_tdata  = rd_beat.tdata;
  assign m_axis_tkeep  = rd_beat.tkeep;
  assign m_axis_tlast  = rd_beat.tlast;
  assign m_axis_tvalid = m_valid_q;
  assign s_axis_tready = s_ready_q;
  assign occupancy     = occ_q;
  assign pkt_count     = pkt_q;

endmodule
